// File: rtl/cdb_pkg.sv
// Common Data Bus definitions shared by the arbiter, the Registers block and the reservation stations.
package cdb_pkg;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int NO_TAG = 0;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic              valid;
    tag_t              tag;
    logic [DATA_W-1:0] data;
  } cdb_beat_t;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index at or after rr_ptr, wrapping, one-hot out.
module rr_picker #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible_i,
  input  logic [PTR_W-1:0] rr_ptr_i,
  output logic [N-1:0]     grant_o
);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;
  logic             found_s;

  // Scan from rr_ptr upward; the sum is one bit wider so the wrap is an explicit compare-and-subtract.
  always_comb begin
    grant_o = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, rr_ptr_i} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(N)) begin
        sum_s = sum_s - (PTR_W+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!found_s && eligible_i[idx_s]) begin
        grant_o[idx_s] = 1'b1;
        found_s        = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that registers one functional-unit result per cycle onto the CDB.
// Optional per-unit saturating grant counters are enabled with CDB_GRANT_STATS_EN.
module cdb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = cdb_pkg::DATA_W,
  parameter int TAG_W  = cdb_pkg::TAG_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*TAG_W-1:0]  req_tag,
  input  logic                    flush,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       CDB_data,
  output logic [TAG_W-1:0]        CDB_source,
  output logic                    CDB_write,
  output logic                    tag_error
`ifdef CDB_GRANT_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     grant_count
`endif
);

  import cdb_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  logic [N_REQ-1:0]  eligible_s;
  logic [N_REQ-1:0]  pick_s;
  logic [N_REQ-1:0]  grant_s;
  logic              tag_bad_s;
  logic [PTR_W-1:0]  g_idx_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [TAG_W-1:0]  sel_tag_s;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [TAG_W-1:0]  cdb_source_q, cdb_source_d;
  logic              cdb_write_q, cdb_write_d;
  logic              tag_error_q, tag_error_d;

  rr_picker #(.N(N_REQ), .PTR_W(PTR_W)) u_picker (
    .eligible_i (eligible_s),
    .rr_ptr_i   (rr_ptr_q),
    .grant_o    (pick_s)
  );

  // Eligibility, illegal-tag detection and the squashable grant.
  always_comb begin
    eligible_s = '0;
    tag_bad_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible_s[i] = req[i] && (req_tag[i*TAG_W +: TAG_W] != TAG_W'(NO_TAG));
      tag_bad_s     = tag_bad_s | (req[i] && (req_tag[i*TAG_W +: TAG_W] == TAG_W'(NO_TAG)));
    end
    if (reset || flush) begin
      grant_s = '0;
    end else begin
      grant_s = pick_s;
    end
  end

  assign grant = grant_s;

  // Encode the granted unit and select its beat.
  always_comb begin
    g_idx_s    = '0;
    sel_data_s = '0;
    sel_tag_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i]) begin
        g_idx_s    = PTR_W'(i);
        sel_data_s = req_data[i*DATA_W +: DATA_W];
        sel_tag_s  = req_tag[i*TAG_W +: TAG_W];
      end else begin
        g_idx_s = g_idx_s;
      end
    end
  end

  // Next-state for the broadcast register, pointer and sticky error.
  always_comb begin
    cdb_write_d = |grant_s;
    tag_error_d = tag_error_q | tag_bad_s;
    if (cdb_write_d) begin
      cdb_data_d   = sel_data_s;
      cdb_source_d = sel_tag_s;
      if (g_idx_s == PTR_W'(N_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = g_idx_s + PTR_W'(1);
      end
    end else begin
      cdb_data_d   = cdb_data_q;
      cdb_source_d = cdb_source_q;
      rr_ptr_d     = rr_ptr_q;
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr_q     <= '0;
      cdb_data_q   <= '0;
      cdb_source_q <= '0;
      cdb_write_q  <= 1'b0;
      tag_error_q  <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      cdb_data_q   <= cdb_data_d;
      cdb_source_q <= cdb_source_d;
      cdb_write_q  <= cdb_write_d;
      tag_error_q  <= tag_error_d;
    end
  end

  assign CDB_data   = cdb_data_q;
  assign CDB_source = cdb_source_q;
  assign CDB_write  = cdb_write_q;
  assign tag_error  = tag_error_q;

`ifdef CDB_GRANT_STATS_EN
  logic [15:0] cnt_q [N_REQ];
  logic [15:0] cnt_d [N_REQ];

  // Saturating per-unit grant counters; flushed cycles never grant so never count.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_s[i] && (cnt_q[i] != 16'hFFFF)) begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
      grant_count[i*16 +: 16] = cnt_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then randomized handshake traffic vs a reference model.
module tb_cdb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int TW = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic            flush;
  logic [N-1:0]    grant;
  logic [DW-1:0]   CDB_data;
  logic [TW-1:0]   CDB_source;
  logic            CDB_write;
  logic            tag_error;
`ifdef CDB_GRANT_STATS_EN
  logic [N*16-1:0] grant_count;
`endif

  logic [DW-1:0] d [N];
  logic [TW-1:0] t [N];

  cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .flush      (flush),
    .grant      (grant),
    .CDB_data   (CDB_data),
    .CDB_source (CDB_source),
    .CDB_write  (CDB_write),
    .tag_error  (tag_error)
`ifdef CDB_GRANT_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  always #5 clock = ~clock;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = d[i];
      req_tag[i*TW +: TW]  = t[i];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_ptr;
  logic          m_write;
  logic [DW-1:0] m_data;
  logic [TW-1:0] m_src;
  logic          m_err;
  int            m_cnt [N];
  int            last_g;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int model_pick();
    if (flush) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req[idx] && t[idx] != 0) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_write = 1'b0;
    m_data  = '0;
    m_src   = '0;
    m_err   = 1'b0;
    last_g  = -1;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic clear_inputs();
    req   = '0;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      d[i] = '0;
      t[i] = '0;
    end
  endtask

  task automatic check_cdb(input string pfx);
    check_val({pfx, "_write"}, CDB_write, m_write);
    check_val({pfx, "_err"}, tag_error, m_err);
    if (m_write) begin
      check_val({pfx, "_src"}, CDB_source, m_src);
      check_val({pfx, "_data"}, CDB_data, m_data);
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic do_cycle(input string pfx);
    int g;
    logic [N-1:0] eg;
    #1;
    g  = model_pick();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    check_val({pfx, "_grant"}, grant, eg);
    @(posedge clock);
    for (int i = 0; i < N; i++) if (req[i] && t[i] == 0) m_err = 1'b1;
    if (g >= 0) begin
      m_write = 1'b1;
      m_data  = d[g];
      m_src   = t[g];
      m_ptr   = (g + 1) % N;
      m_cnt[g]++;
    end else begin
      m_write = 1'b0;
    end
    last_g = g;
    @(negedge clock);
    check_cdb(pfx);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clock);
    apply_reset();

    // Reset state
    #1;
    check_val("rst_grant", grant, 4'b0000);
    check_val("rst_write", CDB_write, 1'b0);
    check_val("rst_src", CDB_source, 6'd0);
    check_val("rst_err", tag_error, 1'b0);
    @(negedge clock);

    // Single requester
    req[1] = 1'b1; t[1] = 6'd1; d[1] = 32'd25;
    #1;
    check_val("single_grant_const", grant, 4'b0010);
    do_cycle("single");
    check_val("single_src_const", CDB_source, 6'd1);
    check_val("single_data_const", CDB_data, 32'd25);
    req[1] = 1'b0;
    do_cycle("single_idle");

    // Round robin from reset, all four continuously requesting
    apply_reset();
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1;
      t[i]   = TW'(i + 1);
      d[i]   = DW'((i + 1) * 10);
    end
    for (int c = 0; c < 5; c++) do_cycle("rr");
    check_val("rr_last_src_const", CDB_source, 6'd1);
    req = '0;
    do_cycle("rr_idle");

    // Illegal tag
    req[2] = 1'b1; t[2] = 6'd0; d[2] = 32'd99;
    req[3] = 1'b1; t[3] = 6'd3; d[3] = 32'd21;
    do_cycle("badtag");
    check_val("badtag_err_const", tag_error, 1'b1);
    req = '0;
    do_cycle("badtag_sticky");
    check_val("badtag_sticky_const", tag_error, 1'b1);

    // Flush leaves pointer alone: units 1 and 3 both request, pointer is 0
    req[1] = 1'b1; t[1] = 6'd2; d[1] = 32'd55;
    req[3] = 1'b1; t[3] = 6'd7; d[3] = 32'd66;
    flush = 1'b1;
    do_cycle("flush");
    flush = 1'b0;
    do_cycle("postflush");
    check_val("postflush_src_const", CDB_source, 6'd2);
    req = '0;
    do_cycle("postflush_idle");

    // Async reset mid-broadcast
    req[2] = 1'b1; t[2] = 6'd5; d[2] = 32'd77;
    do_cycle("prerst");
    reset = 1'b1;
    #1;
    check_val("midrst_write", CDB_write, 1'b0);
    check_val("midrst_grant", grant, 4'b0000);
    check_val("midrst_err", tag_error, 1'b0);
    model_reset();
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      req[i] = 1'b1;
      t[i]   = TW'(i + 1);
      d[i]   = DW'(i + 100);
    end
    #1;
    check_val("rst_restart_const", grant, 4'b0001);
    do_cycle("restart");

    // Randomized traffic obeying the handshake
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (i == last_g) begin
          if ($urandom_range(1, 0) == 1) begin
            d[i] = $urandom();
            t[i] = TW'($urandom_range(63, 1));
          end else begin
            req[i] = 1'b0;
          end
        end else if (req[i]) begin
          if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          d[i]   = $urandom();
          t[i]   = ($urandom_range(39, 0) == 0) ? 6'd0 : TW'($urandom_range(63, 1));
        end
      end
      flush = ($urandom_range(9, 0) == 0);
      do_cycle("rand");
    end

`ifdef CDB_GRANT_STATS_EN
    for (int i = 0; i < N; i++) begin
      check_val("stats_cnt", grant_count[i*16 +: 16], 64'(m_cnt[i]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single Common Data Bus between N functional-unit result buffers in the Tomasulo datapath.
- Each cycle it picks one pending result by round-robin and registers it onto the CDB.
- Its CDB outputs drive In_data, In_source and write of the Registers block and the reservation-station snoop ports.
- Tag 0 means "no producer", so it is never broadcast.

Parameters:
- N_REQ, 4, number of requesting functional units (2..8).
- DATA_W, 32, result width (signed).
- TAG_W, 6, reservation-station tag width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-unit result-valid request; held until granted.
- req_data  in  N_REQ*DATA_W  packed results; unit i occupies bits [i*DATA_W +: DATA_W].
- req_tag  in  N_REQ*TAG_W  packed producing-RS tags; unit i occupies bits [i*TAG_W +: TAG_W].
- flush  in  1  synchronous squash of the broadcast being registered this cycle.
- grant  out  N_REQ  one-hot, combinational; the unit's result is accepted this cycle.
- CDB_data  out  DATA_W  broadcast result (registered).
- CDB_source  out  TAG_W  broadcast tag (registered).
- CDB_write  out  1  broadcast valid (registered).
- tag_error  out  1  sticky flag: a request carried tag 0.

Behaviour:
- Reset (async, asserted): CDB_data=0, CDB_source=0, CDB_write=0, tag_error=0, rr_ptr=0. grant is 0 while reset is high.
- Eligibility: eligible[i] = req[i] && req_tag[i] != 0.
- Illegal tag: req[i] with tag 0 is never granted and sets tag_error on the next edge. tag_error clears only on reset.
- Grant selection is combinational: search eligible starting at index rr_ptr, ascending, wrapping at N_REQ-1 to 0. The first hit gets grant. At most one grant bit is high; all zero if none eligible.
- Handshake:
  - A unit samples grant[i] at the rising edge. If high, the result is consumed and the unit must drop req or present its next result in the following cycle.
  - If grant[i] is low, the unit holds req, data and tag stable.
  - Deasserting req without a grant is permitted (withdrawal).
- Latency: grant in cycle t produces CDB_write=1 with the granted data/tag in cycle t+1, for exactly one cycle per grant.
- Idle: with no grant, CDB_write=0 next cycle. CDB_data and CDB_source hold their last values and are don't-care.
- Pointer update: on a grant to unit g, rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds.
- Fairness: any continuously requesting unit is granted within N_REQ cycles.
- flush=1:
  - grant forced to 0, so no unit consumes its result.
  - CDB_write <= 0 next cycle. rr_ptr holds.
  - tag_error detection still operates.
- Simultaneous requests: resolved purely by rr_ptr order, with no tag-based priority.
- Reset mid-operation: any registered broadcast is dropped immediately. No grant issued in the reset cycle is honoured.
- Widths: no arithmetic on data; rr_ptr width is clog2(N_REQ), and wrap is explicit compare-and-reset (not power-of-two masking).

Optional Feature:
- Macro CDB_GRANT_STATS_EN.
- Defined: adds output grant_count, N_REQ*16 bits. It holds one 16-bit saturating counter per unit, incremented on each non-flushed grant. Counters reset to 0 on reset and stick at 16'hFFFF.
- Undefined: port and counters absent; otherwise identical behaviour.

Decomposition:
- Package cdb_pkg:
  - DATA_W and TAG_W constants.
  - NO_TAG = 0.
  - A typedef for the tag, plus a struct {valid, tag, data} for a CDB beat.
  - Shared with the Registers block and the reservation stations.
- Sub-module rr_picker: purely combinational, taking (eligible, rr_ptr) and returning a one-hot grant. The arbiter holds the registers, flush, error and stats logic.

Test Plan:
- Reset: after reset release with req=0 -> CDB_write=0, CDB_source=0, tag_error=0, grant=0.
- Single requester: req=4'b0010, tag=1, data=25 -> grant=4'b0010 in the same cycle; next cycle CDB_write=1, CDB_source=1, CDB_data=25; the cycle after, CDB_write=0 once req is dropped.
- Round-robin, all four requesting continuously:
  - Tags 1..4, data 10,20,30,40, from reset.
  - Grants go to units 0,1,2,3,0 on consecutive cycles.
  - CDB_source goes 1,2,3,4,1 one cycle later, with no idle cycle.
- Illegal tag: unit 2 requests with tag 0 and unit 3 with tag 3, data 21 -> only unit 3 is granted; CDB shows source 3, data 21; tag_error=1 and stays 1.
- flush: unit 1 requests (tag 2) with flush=1 for one cycle -> grant=0, next cycle CDB_write=0; unit 1 is granted the following cycle with rr_ptr unchanged.
- Async reset mid-broadcast: assert reset while CDB_write=1 -> CDB_write drops before the next clock edge; after release, arbitration restarts from unit 0.
